clb_cfg_loader: RTL and testbench
=================================

CLB_CFG_LOADER -- requirements
Module: clb_cfg_loader

Interface
REQ-001 Parameter SYNC_WORD, default 8'hF2: frame sync pattern, MSB first.
REQ-002 Parameter CFG_W, default 37: configuration word width; fixed at 37 for field map REQ-011.
REQ-003 K  input  1: sole clock; all state changes on rising edge.
REQ-004 RST  input  1: reset, asynchronous, active-high.
REQ-005 DIN  input  1: serial bitstream data, MSB first.
REQ-006 DVALID  input  1: DIN qualifier; a bit is accepted on an edge where DVALID=1 and DREADY=1.
REQ-007 DREADY  output  1: loader accepts bits; high in HUNT and LOAD only.
REQ-008 RESTART  input  1: return to HUNT from LOAD/DONE/ERROR.
REQ-009 CFG  output  CFG_W: active CLB configuration word.
REQ-010 CFG_DONE, CFG_ERR  output  1 each: sticky frame-good / frame-bad status.
REQ-011 CFG field map: [15:0] LUT mem, [17:16] comboption, [19:18] mux2sel, [21:20] mux3sel, [23:22] mux4sel, [25:24] mux5sel, [27:26] mux6sel, [30:28] o2m1_0/o2m2_0/o2m3_0, [33:31] o2m1_1/o2m2_1/o2m3_1, [35:34] DQmux1/DQmux2, [36] floporlatch.
REQ-012 RB_REQ  input  1, RB_OUT  output  1, RB_VALID  output  1: readback port (REQ-030).

Function
REQ-013 States: HUNT, LOAD, CHECK, DONE, ERROR.
REQ-014 HUNT: each accepted bit shifts into 8-bit sync register; when register value after shift equals SYNC_WORD, next state LOAD, bit counter cleared.
REQ-015 LOAD: accepted bits shift into shadow register (CFG_W bits), then one parity bit; counter counts 0..CFG_W.
REQ-016 Parity: even; XOR of CFG_W data bits and parity bit SHALL be 0 for a good frame.
REQ-017 Acceptance of parity bit on edge t -> CHECK during cycle t+1; DREADY=0 in CHECK.
REQ-018 CHECK, parity good: on edge t+1 CFG <= shadow, CFG_DONE <= 1, CFG_ERR <= 0, state DONE.
REQ-019 CHECK, parity bad: on edge t+1 CFG unchanged, CFG_ERR <= 1, CFG_DONE <= 0, state ERROR.
REQ-020 DONE/ERROR: DREADY=0; DVALID ignored; status flags held until RESTART.
REQ-021 RESTART=1 in DONE/ERROR: next state HUNT, CFG_DONE and CFG_ERR cleared, sync register cleared, CFG unchanged.
REQ-022 RESTART=1 in LOAD: partial frame discarded, state HUNT, CFG and flags unchanged.
REQ-023 RESTART=1 in HUNT or CHECK: ignored (CHECK always completes).
REQ-024 RESTART and DVALID on same edge in LOAD: RESTART wins; bit discarded.
REQ-025 DVALID=0 in HUNT/LOAD: no shift, no count; gaps of any length allowed.
REQ-026 CFG changes only in CHECK with good parity; never mid-frame.

Reset
REQ-027 RST=1 asynchronously forces: state HUNT, counters/sync/shadow 0, CFG_DONE=0, CFG_ERR=0, RB_VALID=0, RB_OUT=0.
REQ-028 CFG reset value 37'h03_80A8_0116 (mem 16'h0116, mux2/3/4 sel 2'b10, o2m*_1=1, all else 0).
REQ-029 RST asserted mid-frame or mid-readback: operation aborted, no partial CFG update.

Configuration
REQ-030 Macro CLB_CFG_READBACK_EN defined: RB_REQ=1 in DONE with no readback active starts readback; from next edge RB_VALID=1 for exactly CFG_W cycles, RB_OUT = CFG MSB first; RB_REQ ignored while active; RESTART aborts readback (RB_VALID=0 next edge).
REQ-031 Macro undefined: RB_OUT and RB_VALID tied 0, RB_REQ ignored, no readback logic present.

Verification
REQ-032 Reset: RST pulse -> CFG=37'h03_80A8_0116, DREADY=1, CFG_DONE=0, CFG_ERR=0.
REQ-033 Good frame: 8'hF2, data 37'h1F_0000_FFFF, parity 1 -> CFG=37'h1F_0000_FFFF and CFG_DONE=1 one edge after parity bit, DREADY=0.
REQ-034 Bad parity: same frame, parity 0 -> CFG_ERR=1, CFG stays prior value; RESTART -> flags 0, DREADY=1.
REQ-035 Noise then sync: bits 1,0,1 then 8'hF2 with DVALID gaps of 3 cycles -> frame loads correctly; RESTART after 10 data bits -> HUNT, CFG unchanged.
REQ-036 Readback (macro on): after good frame 37'h00_0000_0001, RB_REQ pulse -> RB_VALID high 37 cycles, RB_OUT 0 for 36 cycles then 1; macro off -> RB_VALID stays 0.
REQ-037 Async reset mid-LOAD (after 20 data bits) -> immediate HUNT, CFG=reset value, no CFG_DONE.

Source files
------------

// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------------------------
// clb_cfg_loader
//   Serial configuration loader for one CLB. It hunts for a sync byte in a qualified bitstream.
//   It then shifts a CFG_W-bit configuration word and one even-parity bit into a shadow
//   register. The active configuration is updated only when a complete frame passes parity.
//
//   Optional feature: define CLB_CFG_READBACK_EN to add a serial readback port. This port
//   shifts the active CFG out MSB first while the loader sits in DONE. When the macro is not
//   defined, rb_out and rb_valid are tied low.
//
// Ports
//   k         in   clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset
//   din       in   serial data, MSB first
//   dvalid    in   din qualifier; a bit is taken when dvalid & dready
//   dready    out  loader accepts bits (HUNT and LOAD only)
//   restart   in   return to HUNT from LOAD / DONE / ERROR
//   cfg       out  active CLB configuration word
//   cfg_done  out  sticky: last frame good
//   cfg_err   out  sticky: last frame failed parity
//   rb_req    in   readback request (DONE only)
//   rb_out    out  readback serial data, MSB first
//   rb_valid  out  readback data qualifier
// ---------------------------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter logic [7:0]  SYNC_WORD = 8'hF2,
    parameter int unsigned CFG_W     = 37
) (
    input  logic             k,
    input  logic             rst,
    input  logic             din,
    input  logic             dvalid,
    output logic             dready,
    input  logic             restart,
    output logic [CFG_W-1:0] cfg,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             rb_req,
    output logic             rb_out,
    output logic             rb_valid
);

    localparam int unsigned      CntW   = $clog2(CFG_W + 1);
    // mem 16'h0116, mux2/3/4 sel = 2'b10, o2m*_1 = 1, everything else 0
    localparam logic [CFG_W-1:0] CfgRst = CFG_W'(37'h03_80A8_0116);

    typedef enum logic [2:0] {StHunt, StLoad, StCheck, StDone, StError} state_e;

    state_e            state_q;
    logic              dready_q;
    // Only the 7 most recent bits are kept; the incoming bit completes the 8-bit window.
    logic [6:0]        sync_q;
    logic [CFG_W-1:0]  shadow_q;
    logic [CntW-1:0]   cnt_q;
    logic              par_q;
    logic [CFG_W-1:0]  cfg_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic [7:0]        sync_shift;

    assign accept     = dvalid & dready_q;
    assign sync_shift = {sync_q, din};

`ifdef CLB_CFG_READBACK_EN
    logic              rb_valid_q;
    logic              rb_out_q;
    logic [CFG_W-1:0]  rb_sh_q;
    logic [CntW-1:0]   rb_cnt_q;
`endif

    always_ff @(posedge k or posedge rst) begin
        if (rst) begin
            state_q  <= StHunt;
            dready_q <= 1'b1;
            sync_q   <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            cfg_q    <= CfgRst;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef CLB_CFG_READBACK_EN
            rb_valid_q <= 1'b0;
            rb_out_q   <= 1'b0;
            rb_sh_q    <= '0;
            rb_cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (accept) begin
                        sync_q <= sync_shift[6:0];
                        if (sync_shift == SYNC_WORD) begin
                            state_q <= StLoad;
                            cnt_q   <= '0;
                            par_q   <= 1'b0;
                        end
                    end
                end
                StLoad: begin
                    // restart wins over a bit offered on the same edge
                    if (restart) begin
                        state_q <= StHunt;
                        sync_q  <= '0;
                    end else if (accept) begin
                        par_q <= par_q ^ din;
                        if (cnt_q == CntW'(CFG_W)) begin
                            state_q  <= StCheck;
                            dready_q <= 1'b0;
                        end else begin
                            shadow_q <= {shadow_q[CFG_W-2:0], din};
                            cnt_q    <= cnt_q + CntW'(1);
                        end
                    end
                end
                StCheck: begin
                    // par_q holds the XOR of all data bits and the parity bit
                    if (!par_q) begin
                        cfg_q   <= shadow_q;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StError;
                    end
                end
                StDone, StError: begin
                    if (restart) begin
                        state_q  <= StHunt;
                        dready_q <= 1'b1;
                        sync_q   <= '0;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StHunt;
                    dready_q <= 1'b1;
                end
            endcase

`ifdef CLB_CFG_READBACK_EN
            // Readback can only run in DONE, so a restart while active always aborts it.
            if (rb_valid_q) begin
                if (restart || (rb_cnt_q == '0)) begin
                    rb_valid_q <= 1'b0;
                    rb_out_q   <= 1'b0;
                end else begin
                    rb_out_q <= rb_sh_q[CFG_W-1];
                    rb_sh_q  <= {rb_sh_q[CFG_W-2:0], 1'b0};
                    rb_cnt_q <= rb_cnt_q - CntW'(1);
                end
            end else if ((state_q == StDone) && rb_req && !restart) begin
                rb_valid_q <= 1'b1;
                rb_out_q   <= cfg_q[CFG_W-1];
                rb_sh_q    <= {cfg_q[CFG_W-2:0], 1'b0};
                rb_cnt_q   <= CntW'(CFG_W - 1);
            end
`endif
        end
    end

    assign dready   = dready_q;
    assign cfg      = cfg_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

`ifdef CLB_CFG_READBACK_EN
    assign rb_out   = rb_out_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_rb_req;
    assign unused_rb_req = rb_req;
    assign rb_out        = 1'b0;
    assign rb_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_clb_cfg_loader.sv
// ---------------------------------------------------------------------------------------------
// tb_clb_cfg_loader
//   Directed self-checking bench for clb_cfg_loader. A table of frames with hand-computed
//   results is replayed in a loop. Hand-written sequences then cover gaps, noise,
//   restart corner cases, readback and asynchronous reset.
// ---------------------------------------------------------------------------------------------
module tb_clb_cfg_loader;

    localparam logic [36:0] CfgRst = 37'h03_80A8_0116;
    localparam logic [7:0]  Sync   = 8'hF2;

    logic        k = 1'b0;
    logic        rst;
    logic        din;
    logic        dvalid;
    logic        dready;
    logic        restart;
    logic [36:0] cfg;
    logic        cfg_done;
    logic        cfg_err;
    logic        rb_req;
    logic        rb_out;
    logic        rb_valid;

    clb_cfg_loader dut (
        .k        (k),
        .rst      (rst),
        .din      (din),
        .dvalid   (dvalid),
        .dready   (dready),
        .restart  (restart),
        .cfg      (cfg),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .rb_req   (rb_req),
        .rb_out   (rb_out),
        .rb_valid (rb_valid)
    );

    always #5 k = ~k;

    typedef struct {
        logic [36:0] data;
        logic        par;
        logic        exp_done;
        logic        exp_err;
        logic [36:0] exp_cfg;
    } vec_t;

    vec_t        vecs[7];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [36:0] prev_cfg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send_bit(input logic b, input int gap);
        din    = b;
        dvalid = 1'b1;
        @(negedge k);
        dvalid = 1'b0;
        din    = 1'b0;
        repeat (gap) @(negedge k);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_frame(input logic [36:0] data, input logic par);
        send_bits({56'd0, Sync}, 8, 0);
        send_bits({27'd0, data}, 37, 0);
        send_bit(par, 0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge k);
        restart = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        din     = 1'b0;
        dvalid  = 1'b0;
        restart = 1'b0;
        rb_req  = 1'b0;

        vecs[0] = '{37'h1F_0000_FFFF, 1'b1, 1'b1, 1'b0, 37'h1F_0000_FFFF};
        vecs[1] = '{37'h1F_0000_FFFF, 1'b0, 1'b0, 1'b1, 37'h1F_0000_FFFF};
        vecs[2] = '{37'h12_3456_789A, 1'b1, 1'b1, 1'b0, 37'h12_3456_789A};
        vecs[3] = '{37'h00_0000_0000, 1'b1, 1'b0, 1'b1, 37'h12_3456_789A};
        vecs[4] = '{37'h00_0000_0000, 1'b0, 1'b1, 1'b0, 37'h00_0000_0000};
        vecs[5] = '{37'h1F_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 37'h00_0000_0000};
        vecs[6] = '{37'h00_0000_0001, 1'b1, 1'b1, 1'b0, 37'h00_0000_0001};

        // Reset
        repeat (2) @(negedge k);
        chk("rst_cfg_during", {27'd0, cfg}, {27'd0, CfgRst});
        rst = 1'b0;
        @(negedge k);
        chk("rst_cfg", {27'd0, cfg}, {27'd0, CfgRst});
        chk("rst_dready", {63'd0, dready}, 64'd1);
        chk("rst_done", {63'd0, cfg_done}, 64'd0);
        chk("rst_err", {63'd0, cfg_err}, 64'd0);
        chk("rst_rb_valid", {63'd0, rb_valid}, 64'd0);
        chk("rst_rb_out", {63'd0, rb_out}, 64'd0);

        // Table-driven frames
        prev_cfg = CfgRst;
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].par);
            chk("check_dready", {63'd0, dready}, 64'd0);
            chk("check_cfg_held", {27'd0, cfg}, {27'd0, prev_cfg});
            @(negedge k);
            chk("frame_cfg", {27'd0, cfg}, {27'd0, vecs[v].exp_cfg});
            chk("frame_done", {63'd0, cfg_done}, {63'd0, vecs[v].exp_done});
            chk("frame_err", {63'd0, cfg_err}, {63'd0, vecs[v].exp_err});
            chk("end_dready", {63'd0, dready}, 64'd0);
            send_bit(1'b1, 0);
            send_bit(1'b0, 0);
            chk("end_flag_held", {62'd0, cfg_done, cfg_err},
                {62'd0, vecs[v].exp_done, vecs[v].exp_err});
            chk("end_cfg_held", {27'd0, cfg}, {27'd0, vecs[v].exp_cfg});
            do_restart();
            chk("rs_done", {63'd0, cfg_done}, 64'd0);
            chk("rs_err", {63'd0, cfg_err}, 64'd0);
            chk("rs_dready", {63'd0, dready}, 64'd1);
            chk("rs_cfg", {27'd0, cfg}, {27'd0, vecs[v].exp_cfg});
            prev_cfg = vecs[v].exp_cfg;
        end

        // Noise then sync with 3-cycle gaps; 37'h0A_5A5A_A5A5 has 18 ones -> parity 0
        send_bit(1'b1, 3);
        send_bit(1'b0, 3);
        send_bit(1'b1, 3);
        send_bits({56'd0, Sync}, 8, 3);
        send_bits({27'd0, 37'h0A_5A5A_A5A5}, 37, 3);
        send_bit(1'b0, 0);
        chk("gap_check_dready", {63'd0, dready}, 64'd0);
        @(negedge k);
        chk("gap_cfg", {27'd0, cfg}, {27'd0, 37'h0A_5A5A_A5A5});
        chk("gap_done", {63'd0, cfg_done}, 64'd1);
        do_restart();

        // Restart after 10 data bits: partial frame discarded
        send_bits({56'd0, Sync}, 8, 1);
        send_bits({54'd0, 10'h3FF}, 10, 1);
        do_restart();
        chk("partial_dready", {63'd0, dready}, 64'd1);
        chk("partial_cfg", {27'd0, cfg}, {27'd0, 37'h0A_5A5A_A5A5});
        chk("partial_flags", {62'd0, cfg_done, cfg_err}, 64'd0);
        send_frame(37'h1F_0000_FFFF, 1'b1);
        @(negedge k);
        chk("after_partial_cfg", {27'd0, cfg}, {27'd0, 37'h1F_0000_FFFF});
        chk("after_partial_done", {63'd0, cfg_done}, 64'd1);
        do_restart();

        // Restart and a valid bit on the same edge in LOAD: restart wins. 38 zero bits in HUNT
        // never complete a frame, so the loader must still be accepting afterwards.
        send_bits({56'd0, Sync}, 8, 0);
        send_bits(64'h15, 5, 0);
        din     = 1'b1;
        dvalid  = 1'b1;
        restart = 1'b1;
        @(negedge k);
        din     = 1'b0;
        dvalid  = 1'b0;
        restart = 1'b0;
        send_bits(64'd0, 38, 0);
        @(negedge k);
        chk("rs_vs_dv_dready", {63'd0, dready}, 64'd1);
        chk("rs_vs_dv_flags", {62'd0, cfg_done, cfg_err}, 64'd0);
        chk("rs_vs_dv_cfg", {27'd0, cfg}, {27'd0, 37'h1F_0000_FFFF});

        // Restart during CHECK is ignored
        send_frame(37'h00_0000_0001, 1'b1);
        restart = 1'b1;
        @(negedge k);
        restart = 1'b0;
        chk("check_rs_done", {63'd0, cfg_done}, 64'd1);
        chk("check_rs_cfg", {27'd0, cfg}, {27'd0, 37'h00_0000_0001});
        chk("check_rs_dready", {63'd0, dready}, 64'd0);

        // Readback of cfg = 1; rb_req held to show it is ignored while active
        rb_req = 1'b1;
        @(negedge k);
`ifdef CLB_CFG_READBACK_EN
        for (int i = 0; i < 37; i++) begin
            if (i == 30) rb_req = 1'b0;
            chk("rb_valid", {63'd0, rb_valid}, 64'd1);
            chk("rb_out", {63'd0, rb_out}, (i == 36) ? 64'd1 : 64'd0);
            @(negedge k);
        end
        chk("rb_valid_end", {63'd0, rb_valid}, 64'd0);
        rb_req = 1'b1;
        @(negedge k);
        rb_req = 1'b0;
        repeat (4) @(negedge k);
        chk("rb_abort_pre", {63'd0, rb_valid}, 64'd1);
        do_restart();
        chk("rb_abort", {63'd0, rb_valid}, 64'd0);
        chk("rb_abort_out", {63'd0, rb_out}, 64'd0);
`else
        for (int i = 0; i < 5; i++) begin
            chk("rb_off_valid", {63'd0, rb_valid}, 64'd0);
            chk("rb_off_out", {63'd0, rb_out}, 64'd0);
            @(negedge k);
        end
        rb_req = 1'b0;
        do_restart();
`endif

        // Asynchronous reset mid-LOAD after 20 data bits
        send_bits({56'd0, Sync}, 8, 0);
        send_bits(64'hF_FFFF, 20, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cfg", {27'd0, cfg}, {27'd0, CfgRst});
        chk("arst_dready", {63'd0, dready}, 64'd1);
        chk("arst_done", {63'd0, cfg_done}, 64'd0);
        @(negedge k);
        rst = 1'b0;
        send_bits(64'h1_FFFF_FFFF, 18, 0);
        @(negedge k);
        chk("arst_after_done", {63'd0, cfg_done}, 64'd0);
        chk("arst_after_cfg", {27'd0, cfg}, {27'd0, CfgRst});
        chk("arst_after_dready", {63'd0, dready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
